panda_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the integer ALU in the execute stage. It accepts one M-extension operation at a time, sequences a shift-add multiplier or a restoring divider over WIDTH cycles, and returns the result over a valid/ready handshake. The pipeline stalls on ready_o and flushes in-flight work with kill_i.

---
 rtl/panda_muldiv.sv | 148 ++++++++++++++
 tb/tb_panda_muldiv.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/panda_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator, with a valid/ready handshake on both sides.
module panda_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        counter;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     a_orig;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg_prod, neg_q, neg_r, div_zero, ovf;

    logic                 accept;
    logic                 signed_a, signed_b, sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 div_zero_in, ovf_in;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot_mag, rem_mag;

    assign ready_o = (state == IDLE);
    assign accept  = valid_i && ready_o && !kill_i;

    // MULHU, DIVU and REMU treat both operands as unsigned; MULHSU only rs1 signed.
    assign signed_a = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010) ||
                      (op_i == 3'b100) || (op_i == 3'b110);
    assign signed_b = (op_i == 3'b000) || (op_i == 3'b001) ||
                      (op_i == 3'b100) || (op_i == 3'b110);
    assign sign_a   = signed_a && op_a_i[WIDTH-1];
    assign sign_b   = signed_b && op_b_i[WIDTH-1];
    assign mag_a    = sign_a ? -op_a_i : op_a_i;
    assign mag_b    = sign_b ? -op_b_i : op_b_i;

    assign div_zero_in = (op_b_i == '0);
    assign ovf_in      = ((op_i == 3'b100) || (op_i == 3'b110)) &&
                         (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_i == '1);

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    // Shifted remainder can reach WIDTH+1 bits, so the trial subtract carries two extra bits.
    assign div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, b_q};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            counter  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_orig   <= '0;
            acc      <= '0;
            neg_prod <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (kill_i) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op_i;
                        a_q      <= mag_a;
                        b_q      <= mag_b;
                        a_orig   <= op_a_i;
                        neg_prod <= sign_a ^ sign_b;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        counter  <= '0;
                        if (!op_i[2]) begin
                            div_zero <= 1'b0;
                            ovf      <= 1'b0;
                            acc      <= {{WIDTH{1'b0}}, mag_b};
                            state    <= MUL;
                        end else begin
                            div_zero <= div_zero_in;
                            ovf      <= ovf_in;
                            acc      <= {{WIDTH{1'b0}}, mag_a};
                            state    <= (div_zero_in || ovf_in) ? DONE : DIV;
                        end
                    end
                end
                MUL: begin
                    acc     <= {mul_sum, acc[WIDTH-1:1]};
                    counter <= counter + 1'b1;
                    if (counter == LAST) state <= DONE;
                end
                DIV: begin
                    if (!div_diff[WIDTH+1])
                        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else
                        acc <= {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
                    counter <= counter + 1'b1;
                    if (counter == LAST) state <= DONE;
                end
                DONE: begin
                    if (ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid_o  = (state == DONE) && !kill_i;
    assign prod     = neg_prod ? -acc : acc;
    assign quot_mag = acc[WIDTH-1:0];
    assign rem_mag  = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        result_o = '0;
        if (valid_o) begin
            if (!op_q[2]) begin
                result_o = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
            end else if (div_zero) begin
                result_o = op_q[1] ? a_orig : '1;
            end else if (ovf) begin
                result_o = op_q[1] ? '0 : a_orig;
            end else if (op_q[1]) begin
                result_o = neg_r ? -rem_mag : rem_mag;
            end else begin
                result_o = neg_q ? -quot_mag : quot_mag;
            end
        end
    end

endmodule

// File: tb/tb_panda_muldiv.sv
// Directed self-checking bench for panda_muldiv: hand-computed results, latency,
// handshake hold, kill and mid-operation reset.
module tb_panda_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    panda_muldiv #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Drives one request starting mid-cycle; it is accepted on the next rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i    = op;
        op_a_i  = a;
        op_b_i  = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    // Counts cycles after the accept edge until valid_o, checking ready_o stays low.
    task automatic waitResult(output int latency, output logic readyLowOk);
        latency    = 0;
        readyLowOk = 1'b1;
        while (latency < 100) begin
            @(negedge clk_i);
            latency++;
            if (ready_o !== 1'b0) readyLowOk = 1'b0;
            if (valid_o === 1'b1) break;
        end
    endtask

    task automatic retire();
        ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected, input int expLatency);
        int   lat;
        logic rdyOk;
        applyStimulus(op, a, b);
        waitResult(lat, rdyOk);
        checkOutput({tag, "_result"}, result_o, expected);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLatency));
        checkOutput({tag, "_ready_low"}, {31'b0, rdyOk}, 32'd1);
        retire();
    endtask

    initial begin
        int   lat;
        logic rdyOk;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        op_i    = 3'b000;
        op_a_i  = '0;
        op_b_i  = '0;
        kill_i  = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("reset_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("reset_result", result_o, 32'd0);

        runOp("mul_neg",   OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        runOp("mulh_min",  OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33);
        runOp("mulhu_max", OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp("mulhsu",    OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33);
        runOp("div_zero",  OP_DIV,    32'd20,         32'd0,        32'hFFFFFFFF, 1);
        runOp("remu_zero", OP_REMU,   32'd20,         32'd0,        32'd20,       1);
        runOp("div_ovf",   OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
        runOp("rem_ovf",   OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1);
        runOp("div_neg",   OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
        runOp("rem_neg",   OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
        runOp("divu",      OP_DIVU,   32'd100,        32'd7,        32'd14,       33);
        runOp("remu",      OP_REMU,   32'd100,        32'd7,        32'd2,        33);

        // A request presented together with kill_i must not be taken.
        kill_i = 1'b1;
        applyStimulus(OP_MUL, 32'd3, 32'd5);
        kill_i = 1'b0;
        @(negedge clk_i);
        checkOutput("kill_noaccept_ready", {31'b0, ready_o}, 32'd1);

        // Kill a divide in its tenth busy cycle, then start a multiply right after.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk_i);
        kill_i = 1'b1;
        #1;
        checkOutput("kill_cycle_valid", {31'b0, valid_o}, 32'd0);
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        checkOutput("kill_idle_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("kill_idle_valid", {31'b0, valid_o}, 32'd0);
        applyStimulus(OP_MUL, 32'd3, 32'd5);
        waitResult(lat, rdyOk);
        checkOutput("after_kill_result", result_o, 32'd15);
        checkOutput("after_kill_latency", 32'(lat), 32'd33);

        // Consumer stalls five cycles: the result must stay put.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("hold_valid", {31'b0, valid_o}, 32'd1);
            checkOutput("hold_result", result_o, 32'd15);
        end
        retire();
        checkOutput("release_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("release_valid", {31'b0, valid_o}, 32'd0);

        // Reset in the middle of a multiply discards it.
        applyStimulus(OP_MUL, 32'd9, 32'd9);
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        checkOutput("midreset_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("midreset_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("midreset_result", result_o, 32'd0);
        repeat (40) @(negedge clk_i);
        checkOutput("midreset_no_late_valid", {31'b0, valid_o}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
